// File: rtl/sha_mem_arbiter_pkg.sv
// Shared types and widths for the SHA-256 engine memory-port arbiter.
package sha_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OWNER_W = 3;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  typedef logic [OWNER_W-1:0] owner_id_t;

  // Round-robin successor of an engine id, wrapping at n.
  function automatic owner_id_t next_owner(input owner_id_t id, input int unsigned n);
    if (32'(id) + 32'd1 >= n) return '0;
    return id + owner_id_t'(1);
  endfunction

endpackage

// File: rtl/sha_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_picker
  import sha_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] rr_ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] winner
);

  logic               hi_found;
  logic               lo_found;
  logic [OWNER_W-1:0] hi_win;
  logic [OWNER_W-1:0] lo_win;

  // hi_* searches from rr_ptr upward; lo_* is the wrapped fallback from index 0.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_win   = owner_id_t'(i);
      end
      if (req[i] && !hi_found && (i >= 32'(rr_ptr))) begin
        hi_found = 1'b1;
        hi_win   = owner_id_t'(i);
      end
    end
    valid  = lo_found;
    winner = hi_found ? hi_win : lo_win;
  end

endmodule

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ hash engines,
// with burst locking, MAX_BURST preemption and a 2-stage read tag pipe.
module sha_mem_arbiter
  import sha_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t         state_q, state_d;
  owner_id_t          owner_q, owner_d;
  owner_id_t          rr_ptr_q, rr_ptr_d;
  owner_id_t          rd_id_q, rd_id_d;
  logic               rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic               pick_valid;
  owner_id_t          pick_winner;
  logic [NUM_REQ-1:0] own_sel;
  logic               own_req, own_lock, own_we;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic               others_pending;
  logic               release_own;
  logic [CNT_W-1:0]   cnt_inc;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    own_sel   = '0;
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(owner_q) == i) begin
        own_sel[i] = 1'b1;
        own_req    = req[i];
        own_lock   = lock[i];
        own_we     = we[i];
        own_addr   = addr[ADDR_W*i +: ADDR_W];
        own_wdata  = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign others_pending = |(req & ~own_sel);
  assign cnt_inc        = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    gnt_d       = gnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_vld_d    = 1'b0;
    rd_id_d     = rd_id_q;
    release_own = 1'b0;
    // Second read-tag stage: steer rvalid by the tag, not the current owner.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = rd_vld_q && (32'(rd_id_q) == i);
    end
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          owner_d    = pick_winner;
          beat_cnt_d = '0;
          state_d    = OWNED;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = (32'(pick_winner) == i);
          end
        end
      end
      OWNED: begin
        if (own_req) begin
          mem_we_d    = own_we;
          mem_addr_d  = own_addr;
          mem_wdata_d = own_wdata;
          rd_vld_d    = ~own_we;
          rd_id_d     = owner_q;
          beat_cnt_d  = cnt_inc;
          release_own = !own_lock || ((cnt_inc == CNT_MAX) && others_pending);
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          gnt_d    = '0;
          rr_ptr_d = next_owner(owner_q, NUM_REQ);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_id_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_id_q     <= rd_id_d;
    end
  end

  assign gnt            = gnt_q;
  assign rvalid         = rvalid_q;
  assign rdata          = mem_read_data;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Scoreboard bench for sha_mem_arbiter: engine drivers push expectations, a monitor checks.
module tb_sha_mem_arbiter;

  typedef struct { int eng; logic [31:0] data; } rd_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int owner; int beats; } ten_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req, lock, we;
  logic [63:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   gnt, rvalid;
  logic [31:0]  rdata;
  logic         mem_clk, mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data, mem_read_data;

  int errors = 0;
  int checks = 0;

  rd_t  rd_q[$];
  wr_t  wr_q[$];
  ten_t ten_q[$];
  logic [31:0] shadow [logic [15:0]];
  int   beats_done [4];
  bit   abort [4];

  always #5 clk = ~clk;

  sha_mem_arbiter #(.NUM_REQ(4), .MAX_BURST(20)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .lock           (lock),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {16'h5A5A, a};
  endfunction

  // Synchronous-read memory: unwritten words read back as pat(addr).
  logic [31:0]  mem [0:255];
  logic [255:0] mem_wr;
  always @(posedge mem_clk) begin
    if (!reset_n) mem_wr <= '0;
    else if (mem_we) begin
      mem[mem_addr[7:0]]    <= mem_write_data;
      mem_wr[mem_addr[7:0]] <= 1'b1;
    end
    mem_read_data <= (reset_n && mem_wr[mem_addr[7:0]]) ? mem[mem_addr[7:0]] : pat(mem_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic exp_ten(input int o, input int b);
    ten_t t;
    t.owner = o;
    t.beats = b;
    ten_q.push_back(t);
  endtask

  // Engine e issues n beats from base; burst holds lock on all but the last beat.
  task automatic run_eng(input int e, input int n, input bit wr, input logic [15:0] base,
                         input logic [31:0] wd, input bit burst);
    int beat = 0;
    int guard = 0;
    logic [15:0] a;
    logic [31:0] d;
    rd_t r;
    wr_t w;
    while (beat < n) begin
      @(negedge clk);
      if (abort[e]) break;
      a = base + 16'(beat);
      d = wd + 32'(beat);
      req[e]             = 1'b1;
      we[e]              = wr;
      lock[e]            = burst && (beat != n - 1);
      addr[16*e +: 16]   = a;
      wdata[32*e +: 32]  = d;
      if (gnt[e]) begin
        if (wr) begin
          w.addr = a; w.data = d;
          wr_q.push_back(w);
          shadow[a] = d;
        end else begin
          r.eng = e; r.data = exp_read(a);
          rd_q.push_back(r);
        end
        beat++;
        beats_done[e]++;
      end else if (++guard > 2000) begin
        checks++; errors++;
        $display("FAIL grant_timeout: eng %0d got no grant, required grant within 2000 cycles", e);
        break;
      end
    end
    if (!abort[e]) @(negedge clk);
    req[e] = 1'b0; lock[e] = 1'b0; we[e] = 1'b0;
  endtask

  task automatic wait_beats(input int e, input int n);
    int g = 0;
    while (beats_done[e] < n && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("wait_beats_reached", 64'(beats_done[e] >= n), 64'd1);
  endtask

  task automatic drain();
    int g = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || ten_q.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    chk("drain_rd_q", 64'(rd_q.size()), 64'd0);
    chk("drain_ten_q", 64'(ten_q.size()), 64'd0);
    chk("drain_wr_q", 64'(wr_q.size()), 64'd0);
  endtask

  // Monitor: tenure owner/length, one-hot grant, read returns, write beats.
  bit         in_ten = 1'b0;
  int         t_owner, t_beats;
  logic [3:0] t_gnt;
  initial begin
    rd_t r;
    wr_t w;
    ten_t t;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        in_ten = 1'b0;
      end else begin
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        if (gnt != 4'b0) begin
          if (!in_ten) begin
            in_ten = 1'b1; t_owner = onehot_idx(gnt); t_beats = 0; t_gnt = gnt;
          end else begin
            chk("gnt_stable_in_tenure", 64'(gnt), 64'(t_gnt));
          end
          if ((gnt & req) != 4'b0) t_beats++;
        end else if (in_ten) begin
          in_ten = 1'b0;
          if (ten_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tenure_unexpected: got owner %0d beats %0d, required none", t_owner, t_beats);
          end else begin
            t = ten_q.pop_front();
            chk("tenure_owner", 64'(t_owner), 64'(t.owner));
            chk("tenure_beats", 64'(t_beats), 64'(t.beats));
          end
        end
        if (rvalid != 4'b0) begin
          if (rd_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rvalid_unexpected: got rvalid %0h, required 0", rvalid);
          end else begin
            r = rd_q.pop_front();
            chk("rvalid_engine", 64'(rvalid), 64'(1) << r.eng);
            chk("rdata", 64'(rdata), 64'(r.data));
          end
        end
        if (mem_we) begin
          if (wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_we_unexpected: got mem_we 1 addr %0h, required 0", mem_addr);
          end else begin
            w = wr_q.pop_front();
            chk("mem_addr_write", 64'(mem_addr), 64'(w.addr));
            chk("mem_write_data", 64'(mem_write_data), 64'(w.data));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500000, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin beats_done[i] = 0; abort[i] = 1'b0; end
    repeat (2) @(negedge clk);
    #1;
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_rvalid", 64'(rvalid), 64'd0);
    chk("reset_mem_we", 64'(mem_we), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_write_data", 64'(mem_write_data), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin: all four request single reads, engine 0 twice -> 0,1,2,3,0.
    exp_ten(0, 1); exp_ten(1, 1); exp_ten(2, 1); exp_ten(3, 1); exp_ten(0, 1);
    fork
      begin
        run_eng(0, 1, 1'b0, 16'h0001, 32'h0, 1'b0);
        run_eng(0, 1, 1'b0, 16'h0005, 32'h0, 1'b0);
      end
      run_eng(1, 1, 1'b0, 16'h0002, 32'h0, 1'b0);
      run_eng(2, 1, 1'b0, 16'h0003, 32'h0, 1'b0);
      run_eng(3, 1, 1'b0, 16'h0004, 32'h0, 1'b0);
    join
    drain();

    // Single read: mem[0x10] = 0x5A5A0010 back to engine 0.
    exp_ten(0, 1);
    run_eng(0, 1, 1'b0, 16'h0010, 32'h0, 1'b0);
    drain();

    // Locked burst of 16 reads 0x0000..0x000F from engine 2.
    exp_ten(2, 16);
    run_eng(2, 16, 1'b0, 16'h0000, 32'h0, 1'b1);
    drain();

    // Write then read back 0xDEADBEEF at 0x0020.
    exp_ten(3, 1);
    run_eng(3, 1, 1'b1, 16'h0020, 32'hDEADBEEF, 1'b0);
    drain();
    chk("shadow_write_value", 64'(exp_read(16'h0020)), 64'hDEADBEEF);
    exp_ten(3, 1);
    run_eng(3, 1, 1'b0, 16'h0020, 32'h0, 1'b0);
    drain();

    // Preempt: engine 1 locks 30 beats, engine 3 waits -> 20, then 3, then remaining 10.
    beats_done[1] = 0;
    exp_ten(1, 20); exp_ten(3, 1); exp_ten(1, 10);
    fork
      run_eng(1, 30, 1'b0, 16'h0040, 32'h0, 1'b1);
      begin
        wait_beats(1, 5);
        run_eng(3, 1, 1'b0, 16'h0030, 32'h0, 1'b0);
      end
    join
    drain();

    // Reset during an engine 0 burst, then engine 1 wins from rr_ptr 0.
    beats_done[0] = 0;
    fork
      run_eng(0, 30, 1'b0, 16'h0060, 32'h0, 1'b1);
      begin
        wait_beats(0, 8);
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        abort[0] = 1'b1;
        rd_q.delete();
        #1;
        chk("midreset_gnt", 64'(gnt), 64'd0);
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_mem_we", 64'(mem_we), 64'd0);
        chk("midreset_mem_addr", 64'(mem_addr), 64'd0);
      end
    join
    abort[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_ten(1, 1);
    run_eng(1, 1, 1'b0, 16'h0070, 32'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
